// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Holds the FSM state enum, the drain length and the 16-bit counter saturation helper.
package hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } hz_state_e;

    localparam logic [1:0]  DRAIN_CYCLES = 2'd2;
    localparam logic [15:0] CNT_SAT_MAX  = 16'hFFFF;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == CNT_SAT_MAX) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/hazard_ctrl_sat_cnt16.sv
// 16-bit event counter with increment enable and asynchronous clear.
// The count sticks at the saturation limit instead of wrapping.
module sat_cnt16 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inc_i,
    output logic [15:0] cnt_o
);
    import hazard_ctrl_pkg::*;

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    // Next count: saturating increment when enabled
    always_comb begin
        cnt_d = cnt_q;
        if (inc_i) begin
            cnt_d = sat_inc16(cnt_q);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stall/flush decode for a 5-stage pipe plus hlt drain FSM.
// Enables and clears are combinational; state, drain count and statistics are registered.
module hazard_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  id_rs,
    input  logic [3:0]  id_rt,
    input  logic        id_uses_rs,
    input  logic        id_uses_rt,
    input  logic        ex_mem_read,
    input  logic [3:0]  ex_rd,
    input  logic        ex_redirect,
    input  logic        ex_hlt,
    input  logic        icache_stall,
    input  logic        dcache_stall,
    output logic        pc_we,
    output logic        if_id_we,
    output logic        if_id_clr,
    output logic        id_ex_we,
    output logic        id_ex_clr,
    output logic        ex_mem_we,
    output logic        mem_wb_we,
    output logic        halted,
    output logic [15:0] stall_cycles,
    output logic [15:0] flush_count
);
    import hazard_ctrl_pkg::*;

    hz_state_e  state_q;
    hz_state_e  state_d;
    logic [1:0] drain_q;
    logic [1:0] drain_d;
    logic       load_use_s;
    logic       flush_inc_s;
    logic       stall_inc_s;

    assign load_use_s = ex_mem_read && (ex_rd != 4'd0) &&
                        ((id_uses_rs && (id_rs == ex_rd)) ||
                         (id_uses_rt && (id_rt == ex_rd)));

    // Pipeline enable/clear decode and FSM next state
    always_comb begin
        pc_we       = 1'b1;
        if_id_we    = 1'b1;
        if_id_clr   = 1'b0;
        id_ex_we    = 1'b1;
        id_ex_clr   = 1'b0;
        ex_mem_we   = 1'b1;
        mem_wb_we   = 1'b1;
        flush_inc_s = 1'b0;
        state_d     = state_q;
        drain_d     = drain_q;
        case (state_q)
            RUN: begin
                if (dcache_stall) begin
                    pc_we     = 1'b0;
                    if_id_we  = 1'b0;
                    id_ex_we  = 1'b0;
                    ex_mem_we = 1'b0;
                    mem_wb_we = 1'b0;
                end else if (ex_hlt) begin
                    pc_we     = 1'b0;
                    if_id_we  = 1'b0;
                    if_id_clr = 1'b1;
                    id_ex_we  = 1'b0;
                    id_ex_clr = 1'b1;
                    state_d   = DRAIN;
                    drain_d   = DRAIN_CYCLES;
                end else if (ex_redirect) begin
                    if_id_we    = 1'b0;
                    if_id_clr   = 1'b1;
                    id_ex_we    = 1'b0;
                    id_ex_clr   = 1'b1;
                    flush_inc_s = 1'b1;
                end else if (load_use_s) begin
                    // Hold PC and IF/ID, drop a bubble into EX
                    pc_we     = 1'b0;
                    if_id_we  = 1'b0;
                    id_ex_we  = 1'b0;
                    id_ex_clr = 1'b1;
                end else if (icache_stall) begin
                    pc_we     = 1'b0;
                    if_id_we  = 1'b0;
                    if_id_clr = 1'b1;
                end else begin
                    pc_we = 1'b1;
                end
            end
            DRAIN: begin
                pc_we     = 1'b0;
                if_id_we  = 1'b0;
                if_id_clr = 1'b1;
                id_ex_we  = 1'b0;
                id_ex_clr = 1'b1;
                ex_mem_we = !dcache_stall;
                mem_wb_we = !dcache_stall;
                if (!dcache_stall) begin
                    if (drain_q == 2'd1) begin
                        state_d = HALTED;
                        drain_d = 2'd0;
                    end else begin
                        drain_d = drain_q - 2'd1;
                    end
                end else begin
                    drain_d = drain_q;
                end
            end
            HALTED: begin
                pc_we     = 1'b0;
                if_id_we  = 1'b0;
                id_ex_we  = 1'b0;
                ex_mem_we = 1'b0;
                mem_wb_we = 1'b0;
            end
            default: begin
                // Unreachable encoding: freeze the pipe and recover to RUN
                pc_we     = 1'b0;
                if_id_we  = 1'b0;
                id_ex_we  = 1'b0;
                ex_mem_we = 1'b0;
                mem_wb_we = 1'b0;
                state_d   = RUN;
                drain_d   = 2'd0;
            end
        endcase
    end

    assign stall_inc_s = ((state_q == RUN) || (state_q == DRAIN)) && !pc_we;
    assign halted      = (state_q == HALTED);

    // FSM state and drain countdown registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            drain_q <= 2'd0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
        end
    end

    sat_cnt16 u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (stall_inc_s),
        .cnt_o (stall_cycles)
    );

    sat_cnt16 u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (flush_inc_s),
        .cnt_o (flush_count)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed vectors push hand-computed expectations,
// a negedge monitor pops and compares control outputs and both counters.
module tb_hazard_ctrl;

    logic        clk;
    logic        rst_n;
    logic [3:0]  id_rs, id_rt, ex_rd;
    logic        id_uses_rs, id_uses_rt, ex_mem_read;
    logic        ex_redirect, ex_hlt, icache_stall, dcache_stall;
    logic        pc_we, if_id_we, if_id_clr, id_ex_we, id_ex_clr;
    logic        ex_mem_we, mem_wb_we, halted;
    logic [15:0] stall_cycles, flush_count;

    // {pc_we, if_id_we, if_id_clr, id_ex_we, id_ex_clr, ex_mem_we, mem_wb_we, halted}
    localparam logic [7:0] C_NORM  = 8'b1101_0110;
    localparam logic [7:0] C_DSTL  = 8'b0000_0000;
    localparam logic [7:0] C_HLT   = 8'b0010_1110;
    localparam logic [7:0] C_REDIR = 8'b1010_1110;
    localparam logic [7:0] C_LU    = 8'b0000_1110;
    localparam logic [7:0] C_IC    = 8'b0011_0110;
    localparam logic [7:0] C_DRN   = 8'b0010_1110;
    localparam logic [7:0] C_DRNDS = 8'b0010_1000;
    localparam logic [7:0] C_HALT  = 8'b0000_0001;

    typedef struct {
        int          vec;
        logic [7:0]  ctl;
        logic [15:0] sc;
        logic [15:0] fc;
    } exp_t;

    exp_t exp_q[$];
    int   total_checks;
    int   passed_checks;
    int   vec_no;

    hazard_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_uses_rs   (id_uses_rs),
        .id_uses_rt   (id_uses_rt),
        .ex_mem_read  (ex_mem_read),
        .ex_rd        (ex_rd),
        .ex_redirect  (ex_redirect),
        .ex_hlt       (ex_hlt),
        .icache_stall (icache_stall),
        .dcache_stall (dcache_stall),
        .pc_we        (pc_we),
        .if_id_we     (if_id_we),
        .if_id_clr    (if_id_clr),
        .id_ex_we     (id_ex_we),
        .id_ex_clr    (id_ex_clr),
        .ex_mem_we    (ex_mem_we),
        .mem_wb_we    (mem_wb_we),
        .halted       (halted),
        .stall_cycles (stall_cycles),
        .flush_count  (flush_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int vec, input logic [15:0] got, input logic [15:0] exp);
        total_checks++;
        if (got === exp) begin
            passed_checks++;
        end else begin
            $display("FAIL %s vec=%0d got=%h exp=%h", name, vec, got, exp);
        end
    endtask

    // One cycle of stimulus: drive just after the rising edge, queue the expected response
    task automatic step(input logic rst_v,
                        input logic [3:0] rs, input logic urs, input logic [3:0] rt, input logic urt,
                        input logic mr, input logic [3:0] rd,
                        input logic redir, input logic hlt, input logic ic, input logic dc,
                        input logic [7:0] ectl, input logic [15:0] esc, input logic [15:0] efc);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n = rst_v;
        id_rs = rs; id_uses_rs = urs; id_rt = rt; id_uses_rt = urt;
        ex_mem_read = mr; ex_rd = rd;
        ex_redirect = redir; ex_hlt = hlt; icache_stall = ic; dcache_stall = dc;
        e.vec = vec_no; e.ctl = ectl; e.sc = esc; e.fc = efc;
        exp_q.push_back(e);
        vec_no++;
    endtask

    task automatic idle(input logic rst_v, input logic [7:0] ectl, input logic [15:0] esc, input logic [15:0] efc);
        step(rst_v, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, ectl, esc, efc);
    endtask

    // Monitor: compare whatever the DUT presents against the oldest queued expectation
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("ctl", e.vec, {8'd0, pc_we, if_id_we, if_id_clr, id_ex_we, id_ex_clr,
                               ex_mem_we, mem_wb_we, halted}, {8'd0, e.ctl});
            chk("stall_cycles", e.vec, stall_cycles, e.sc);
            chk("flush_count", e.vec, flush_count, e.fc);
        end
    end

    initial begin
        total_checks = 0; passed_checks = 0; vec_no = 0;
        rst_n = 1'b0;
        id_rs = 4'd0; id_rt = 4'd0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
        ex_mem_read = 1'b0; ex_rd = 4'd0; ex_redirect = 1'b0; ex_hlt = 1'b0;
        icache_stall = 1'b0; dcache_stall = 1'b0;

        // Reset: RUN decode of idle inputs, counters cleared
        idle(1'b0, C_NORM, 16'd0, 16'd0);
        idle(1'b1, C_NORM, 16'd0, 16'd0);
        // Load-use on rt (r3), one stall cycle
        step(1'b1, 4'd0, 1'b0, 4'd3, 1'b1, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0, C_LU, 16'd0, 16'd0);
        idle(1'b1, C_NORM, 16'd1, 16'd0);
        // Load to r0 never stalls
        step(1'b1, 4'd0, 1'b1, 4'd0, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_NORM, 16'd1, 16'd0);
        // Fetch miss alone
        step(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, C_IC, 16'd1, 16'd0);
        idle(1'b1, C_NORM, 16'd2, 16'd0);
        // Redirect beats load-use and fetch miss
        step(1'b1, 4'd5, 1'b1, 4'd0, 1'b0, 1'b1, 4'd5, 1'b1, 1'b0, 1'b1, 1'b0, C_REDIR, 16'd2, 16'd0);
        idle(1'b1, C_NORM, 16'd2, 16'd1);
        // Redirect held under dcache_stall for 3 cycles, counted once on release
        step(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, C_DSTL, 16'd2, 16'd1);
        step(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, C_DSTL, 16'd3, 16'd1);
        step(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, C_DSTL, 16'd4, 16'd1);
        step(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, C_REDIR, 16'd5, 16'd1);
        idle(1'b1, C_NORM, 16'd5, 16'd2);
        // hlt in cycle 0 masks a redirect; drain ignores redirect/icache; dcache in cycle 2
        step(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, C_HLT, 16'd5, 16'd2);
        step(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0, C_DRN, 16'd6, 16'd2);
        step(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, C_DRNDS, 16'd7, 16'd2);
        idle(1'b1, C_DRN, 16'd8, 16'd2);
        step(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, C_HALT, 16'd9, 16'd2);
        step(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1, C_HALT, 16'd9, 16'd2);
        // Reset out of HALTED: immediate RUN decode, counters cleared
        idle(1'b0, C_NORM, 16'd0, 16'd0);
        idle(1'b1, C_NORM, 16'd0, 16'd0);

        // Drive 65534 back-to-back redirects to bring flush_count to 16'hFFFE
        for (int i = 0; i < 65534; i++) begin
            @(posedge clk);
            #1;
            ex_redirect = 1'b1;
        end
        step(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, C_REDIR, 16'd0, 16'hFFFE);
        step(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, C_REDIR, 16'd0, 16'hFFFF);
        step(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, C_REDIR, 16'd0, 16'hFFFF);
        idle(1'b1, C_NORM, 16'd0, 16'hFFFF);

        repeat (3) @(posedge clk);
        total_checks++;
        if (exp_q.size() == 0) begin
            passed_checks++;
        end else begin
            $display("FAIL scoreboard_drain left=%0d exp=0", exp_q.size());
        end
        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have these ports:
- clk, in, 1, rising-edge clock.
- rst_n, in, 1, asynchronous, active-low reset.
- id_rs, in, 4, decode-stage source register 1.
- id_rt, in, 4, decode-stage source register 2.
- id_uses_rs, in, 1, decode instruction reads id_rs.
- id_uses_rt, in, 1, decode instruction reads id_rt.
- ex_mem_read, in, 1, EX-stage instruction is a load.
- ex_rd, in, 4, EX-stage destination register.
- ex_redirect, in, 1, EX resolved taken branch, call or ret.
- ex_hlt, in, 1, EX-stage instruction is hlt.
- icache_stall, in, 1, fetch miss pending.
- dcache_stall, in, 1, memory-stage miss pending.
- pc_we, out, 1, PC write enable.
- if_id_we, out, 1, IF/ID write enable.
- if_id_clr, out, 1, IF/ID bubble insert.
- id_ex_we, out, 1, ID/EX write enable.
- id_ex_clr, out, 1, ID/EX bubble insert.
- ex_mem_we, out, 1, EX/MEM write enable.
- mem_wb_we, out, 1, MEM/WB write enable.
- halted, out, 1, pipeline drained after hlt.
- stall_cycles, out, 16, saturating count of cycles with pc_we=0 outside HALTED.
- flush_count, out, 16, saturating count of accepted redirects.

Function
REQ-002 SHALL implement FSM states RUN, DRAIN, HALTED; enable/clear outputs are combinational from state and inputs; counters and state are registered.
REQ-003 Load-use hazard SHALL be defined as ex_mem_read & ex_rd!=0 & ((id_uses_rs & id_rs==ex_rd) | (id_uses_rt & id_rt==ex_rd)).
REQ-004 RUN priority, highest first:
- dcache_stall: all *_we=0, all *_clr=0.
- ex_hlt: pc_we=0, if_id_clr=1, id_ex_clr=1, ex_mem_we=mem_wb_we=1; next state DRAIN, drain count=2.
- ex_redirect: pc_we=1, if_id_clr=1, id_ex_clr=1, ex_mem_we=mem_wb_we=1; flush_count+1.
- load-use: pc_we=0, if_id_we=0, id_ex_clr=1, ex_mem_we=mem_wb_we=1.
- icache_stall: pc_we=0, if_id_clr=1, id_ex_we=ex_mem_we=mem_wb_we=1.
- otherwise: all *_we=1, all *_clr=0.
REQ-005 A clr output SHALL override the matching we output; the downstream register zeroes its contents and control bits.
REQ-006 In DRAIN:
- pc_we=0, if_id_clr=1, id_ex_clr=1.
- ex_mem_we=mem_wb_we=!dcache_stall.
- Count decrements on each cycle with !dcache_stall.
- The edge at count==1 with !dcache_stall SHALL enter HALTED.
- ex_redirect, load-use and icache_stall SHALL be ignored.
REQ-007 HALTED SHALL be absorbing until reset: all *_we=0, clr=0, halted=1; no counter changes.
REQ-008 stall_cycles SHALL increment on every RUN/DRAIN cycle with pc_we=0, including dcache_stall cycles, and saturate at 16'hFFFF.
REQ-009 flush_count SHALL saturate at 16'hFFFF; a redirect masked by dcache_stall or ex_hlt SHALL NOT count.
REQ-010 A redirect SHALL NOT be counted twice while held under dcache_stall; it counts in the cycle it is accepted.

Reset
REQ-011 On rst_n low, asynchronously:
- state=RUN, drain count=0, stall_cycles=0, flush_count=0, halted=0.
- Combinational outputs SHALL be the RUN decode of current inputs.
REQ-012 Reset asserted in DRAIN or HALTED SHALL return to RUN on the next cycle after release, with counters cleared.

Structure
REQ-013 Shared package SHALL hold the state enum (RUN, DRAIN, HALTED), DRAIN_CYCLES=2 and the 16-bit saturation limit.
REQ-014 One sub-module sat_cnt16 (increment enable, async clear, saturate) SHALL be instantiated twice, for stall_cycles and flush_count.

Verification
REQ-015 Load-use: ex_mem_read=1, ex_rd=3, id_uses_rt=1, id_rt=3 -> pc_we=0, if_id_we=0, id_ex_clr=1 for 1 cycle; stall_cycles=1.
REQ-016 Load-use with ex_rd=0, id_rs=0 -> no stall; all we=1.
REQ-017 Redirect with icache_stall=1 and load-use present -> pc_we=1, if_id_clr=1, id_ex_clr=1; flush_count=1.
REQ-018 dcache_stall held 3 cycles with ex_redirect=1 -> all we=0 for 3 cycles; flush_count stays 0, then becomes 1 on release; stall_cycles=3.
REQ-019 ex_hlt=1 in cycle 0, dcache_stall=1 in cycle 2 -> DRAIN occupies cycles 1-3; halted=1 from cycle 4; all we=0 thereafter; reset returns to RUN.
REQ-020 Force flush_count to 16'hFFFE and issue 3 redirects -> flush_count holds at 16'hFFFF.
